// File: rtl/eth_sb_ctrl_cmd_queue.sv
// Sideband control command queue: validates ctrl wr/rd strobes from the APB FSM,
// buffers accepted commands in order and replays them to the register target.
module eth_sb_ctrl_cmd_queue #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    FIFO_DEPTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE      = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE      = 'h1000,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_eth_sb_ctrl_wr_en,
    input  logic                    i_eth_sb_ctrl_rd_en,
    input  logic [ADDR_WIDTH-1:0]   i_eth_sb_ctrl_addr,
    input  logic [DATA_WIDTH-1:0]   i_eth_sb_ctrl_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_eth_sb_ctrl_pstrb,
    input  logic                    i_fuse_enable,
    output logic [DATA_WIDTH-1:0]   o_eth_sb_ctrl_rdata,
    output logic                    o_eth_sb_ctrl_slverr,
    output logic                    o_eth_sb_ctrl_inv_addr,
    output logic                    o_wdata_resp,
    output logic                    o_rdata_resp,
    output logic                    o_fifo_full,
    output logic                    o_fifo_empty,
    output logic                    o_posted_err,
    input  logic                    i_posted_err_clr,
    output logic                    o_tgt_req_valid,
    input  logic                    i_tgt_req_ready,
    output logic                    o_tgt_req_write,
    output logic [ADDR_WIDTH-1:0]   o_tgt_req_addr,
    output logic [DATA_WIDTH-1:0]   o_tgt_req_wdata,
    output logic [DATA_WIDTH/8-1:0] o_tgt_req_strb,
    input  logic                    i_tgt_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_tgt_rsp_rdata,
    input  logic                    i_tgt_rsp_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0]      TMR_LAST   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [ADDR_WIDTH:0]   WIN_LO     = {1'b0, ADDR_BASE};
    localparam logic [ADDR_WIDTH:0]   WIN_HI     = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
    } cmd_t;

    // front-end response waiting for the FSM-facing outputs
    typedef struct packed {
        logic wr;
        logic err;
        logic inv;
    } rsp_t;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_RSP} state_t;

    cmd_t             mem [FIFO_DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer;

    logic             strobe, push, pop, timeout, addr_ok;
    logic             fe_vld, cmp_rd, cmp_err, wr_fail;
    rsp_t             fe, hold, emit;
    logic             hold_vld;
    logic [ADDR_WIDTH:0] addr_ext;

    assign head            = mem[rd_ptr];
    assign o_tgt_req_valid = (state_q == ST_REQ);
    assign o_tgt_req_write = head.wr;
    assign o_tgt_req_addr  = head.addr;
    assign o_tgt_req_wdata = head.wdata;
    assign o_tgt_req_strb  = head.strb;

    assign addr_ext = {1'b0, i_eth_sb_ctrl_addr};
    assign addr_ok  = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI) &&
                      ((i_eth_sb_ctrl_addr & ALIGN_MASK) == '0);

    // push check in priority order; a dual strobe is reported as a write
    always_comb begin
        strobe = i_eth_sb_ctrl_wr_en | i_eth_sb_ctrl_rd_en;
        push   = 1'b0;
        fe.wr  = i_eth_sb_ctrl_wr_en;
        fe.err = 1'b0;
        fe.inv = 1'b0;
        if (i_eth_sb_ctrl_wr_en && i_eth_sb_ctrl_rd_en) begin
            fe.err = 1'b1;
        end else if (!i_fuse_enable) begin
            fe.err = 1'b1;
        end else if (!addr_ok) begin
            fe.err = 1'b1;
            fe.inv = 1'b1;
        end else if (count == CNT_FULL) begin
            fe.err = 1'b1;
        end else begin
            push = strobe;
        end
        // accepted reads answer later from the target; everything else answers now
        fe_vld = strobe & (fe.err | fe.wr);
    end

    // engine next state; the head is popped when its response or timeout lands
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        timeout = 1'b0;
        case (state_q)
            // registered empty flag delays launch of a fresh push by one cycle;
            // the live count keeps a stale flag from launching right after the last pop
            ST_IDLE:     if (count != '0 && !o_fifo_empty) state_d = ST_REQ;
            ST_REQ:      if (i_tgt_req_ready) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (i_tgt_rsp_valid) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer == TMR_LAST) begin
                    pop     = 1'b1;
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    assign cmp_err = timeout | (i_tgt_rsp_valid & i_tgt_rsp_err);
    assign cmp_rd  = pop & ~head.wr;
    assign wr_fail = pop & head.wr & cmp_err;
    assign emit    = hold_vld ? hold : fe;

    // FSM state and WAIT_RSP timer (zero on every entry)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            timer   <= '0;
        end else begin
            state_q <= state_d;
            timer   <= (state_q == ST_WAIT_RSP) ? timer + TMR_W'(1) : '0;
        end
    end

    // command storage; pointers wrap naturally with a power-of-two depth
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= '{wr: i_eth_sb_ctrl_wr_en, addr: i_eth_sb_ctrl_addr,
                                   wdata: i_eth_sb_ctrl_wdata, strb: i_eth_sb_ctrl_pstrb};
    end

    // pointers, occupancy and registered status
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_fifo_empty <= 1'b1;
            o_fifo_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count        <= count + CNT_W'(push) - CNT_W'(pop);
            o_fifo_empty <= (count == '0);
            o_fifo_full  <= (count == CNT_FULL);
        end
    end

    // response outputs: read completion first, then the held front-end response, then a new one
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wdata_resp           <= 1'b0;
            o_rdata_resp           <= 1'b0;
            o_eth_sb_ctrl_slverr   <= 1'b0;
            o_eth_sb_ctrl_inv_addr <= 1'b0;
            o_eth_sb_ctrl_rdata    <= '0;
            hold_vld               <= 1'b0;
            hold                   <= '0;
        end else begin
            o_wdata_resp           <= 1'b0;
            o_rdata_resp           <= 1'b0;
            o_eth_sb_ctrl_slverr   <= 1'b0;
            o_eth_sb_ctrl_inv_addr <= 1'b0;
            hold_vld               <= 1'b0;
            hold                   <= fe;
            if (cmp_rd) begin
                o_rdata_resp         <= 1'b1;
                o_eth_sb_ctrl_rdata  <= timeout ? '0 : i_tgt_rsp_rdata;
                o_eth_sb_ctrl_slverr <= cmp_err;
                hold_vld             <= fe_vld;
            end else if (hold_vld || fe_vld) begin
                if (emit.wr) begin
                    o_wdata_resp <= 1'b1;
                end else begin
                    o_rdata_resp        <= 1'b1;
                    o_eth_sb_ctrl_rdata <= '0;
                end
                o_eth_sb_ctrl_slverr   <= emit.err;
                o_eth_sb_ctrl_inv_addr <= emit.inv;
                hold_vld               <= hold_vld & fe_vld;
            end
        end
    end

    // sticky posted-write error; a new failure beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (i_reset)               o_posted_err <= 1'b0;
        else if (wr_fail)          o_posted_err <= 1'b1;
        else if (i_posted_err_clr) o_posted_err <= 1'b0;
    end

endmodule

// File: tb/tb_eth_sb_ctrl_cmd_queue.sv
// Bench for eth_sb_ctrl_cmd_queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_eth_sb_ctrl_cmd_queue;
    localparam int DEPTH = 4;
    localparam int TMO   = 255;
    localparam int IDLE  = 0, REQ = 1, WT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, rd_en, fuse, perr_clr, req_ready, rsp_valid, rsp_err;
    logic [31:0] addr, wdata, rsp_rdata;
    logic [3:0]  pstrb;
    logic [31:0] rdata, req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic        slverr, inv_addr, wresp, rresp, full, empty, perr, req_valid, req_write;

    eth_sb_ctrl_cmd_queue dut (
        .i_clk(clk), .i_reset(rst),
        .i_eth_sb_ctrl_wr_en(wr_en), .i_eth_sb_ctrl_rd_en(rd_en),
        .i_eth_sb_ctrl_addr(addr), .i_eth_sb_ctrl_wdata(wdata), .i_eth_sb_ctrl_pstrb(pstrb),
        .i_fuse_enable(fuse),
        .o_eth_sb_ctrl_rdata(rdata), .o_eth_sb_ctrl_slverr(slverr), .o_eth_sb_ctrl_inv_addr(inv_addr),
        .o_wdata_resp(wresp), .o_rdata_resp(rresp),
        .o_fifo_full(full), .o_fifo_empty(empty),
        .o_posted_err(perr), .i_posted_err_clr(perr_clr),
        .o_tgt_req_valid(req_valid), .i_tgt_req_ready(req_ready),
        .o_tgt_req_write(req_write), .o_tgt_req_addr(req_addr),
        .o_tgt_req_wdata(req_wdata), .o_tgt_req_strb(req_strb),
        .i_tgt_rsp_valid(rsp_valid), .i_tgt_rsp_rdata(rsp_rdata), .i_tgt_rsp_err(rsp_err)
    );

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [3:0]  strb;
    } cmd_t;

    int n_chk = 0, n_err = 0;

    // reference model state
    cmd_t      q[$];
    int        m_eng, m_wcnt;
    bit        m_empty, m_full, h_vld, h_wr, h_err, h_inv;
    bit        e_wresp, e_rresp, e_slverr, e_inv, e_perr;
    bit [31:0] e_rdata;

    // target behaviour knobs
    int        rdy_p, rsp_p, err_p;
    bit        tgt_manual, fix_en;
    bit [31:0] fix_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance the model by one clock edge given the inputs currently driven
    task automatic model_edge();
        cmd_t      c, hd;
        bit        strobe, f_vld, f_err, f_inv, f_push, done, tmo, c_rd, w_fail;
        bit [63:0] a;
        int        cnt_now;
        if (rst) begin
            q.delete();
            m_eng = IDLE; m_wcnt = 0; m_empty = 1; m_full = 0; h_vld = 0;
            e_wresp = 0; e_rresp = 0; e_slverr = 0; e_inv = 0; e_perr = 0; e_rdata = 0;
            return;
        end
        strobe = wr_en | rd_en;
        f_err = 0; f_inv = 0; f_push = 0;
        a = {32'h0, addr};
        if (strobe) begin
            if (wr_en && rd_en)                        f_err = 1;
            else if (!fuse)                            f_err = 1;
            else if (a >= 64'h1000 || a % 4 != 0) begin f_err = 1; f_inv = 1; end
            else if (q.size() == DEPTH)                f_err = 1;
            else                                       f_push = 1;
        end
        f_vld   = strobe && (f_err || wr_en);
        cnt_now = q.size();

        done = 0; tmo = 0;
        case (m_eng)
            IDLE: if (cnt_now != 0 && !m_empty) m_eng = REQ;
            REQ:  if (req_ready) begin m_eng = WT; m_wcnt = 0; end
            default: begin
                if (rsp_valid)          done = 1;
                else if (m_wcnt == TMO) begin done = 1; tmo = 1; end
                else                    m_wcnt++;
            end
        endcase
        hd = '{wr: 0, addr: 0, wdata: 0, strb: 0};
        if (done) begin
            hd    = q.pop_front();
            m_eng = IDLE;
        end
        c_rd   = done && !hd.wr;
        w_fail = done && hd.wr && (tmo || rsp_err);
        if (f_push) begin
            c.wr = wr_en; c.addr = addr; c.wdata = wdata; c.strb = pstrb;
            q.push_back(c);
        end
        m_empty = (cnt_now == 0);
        m_full  = (cnt_now == DEPTH);

        e_wresp = 0; e_rresp = 0; e_slverr = 0; e_inv = 0;
        if (c_rd) begin
            e_rresp = 1; e_rdata = tmo ? 32'h0 : rsp_rdata; e_slverr = tmo || rsp_err;
            h_vld = f_vld; h_wr = wr_en; h_err = f_err; h_inv = f_inv;
        end else if (h_vld) begin
            if (h_wr) e_wresp = 1; else begin e_rresp = 1; e_rdata = 0; end
            e_slverr = h_err; e_inv = h_inv;
            h_vld = f_vld; h_wr = wr_en; h_err = f_err; h_inv = f_inv;
        end else if (f_vld) begin
            if (wr_en) e_wresp = 1; else begin e_rresp = 1; e_rdata = 0; end
            e_slverr = f_err; e_inv = f_inv;
            h_vld = 0;
        end
        if (w_fail)        e_perr = 1;
        else if (perr_clr) e_perr = 0;
    endtask

    task automatic check_all();
        chk("wdata_resp", 64'(wresp), 64'(e_wresp));
        chk("rdata_resp", 64'(rresp), 64'(e_rresp));
        chk("rdata", 64'(rdata), 64'(e_rdata));
        chk("slverr", 64'(slverr), 64'(e_slverr));
        chk("inv_addr", 64'(inv_addr), 64'(e_inv));
        chk("fifo_full", 64'(full), 64'(m_full));
        chk("fifo_empty", 64'(empty), 64'(m_empty));
        chk("posted_err", 64'(perr), 64'(e_perr));
        chk("req_valid", 64'(req_valid), 64'(m_eng == REQ));
        if (m_eng == REQ && q.size() > 0) begin
            chk("req_write", 64'(req_write), 64'(q[0].wr));
            chk("req_addr", 64'(req_addr), 64'(q[0].addr));
            chk("req_wdata", 64'(req_wdata), 64'(q[0].wdata));
            chk("req_strb", 64'(req_strb), 64'(q[0].strb));
        end
    endtask

    task automatic step();
        if (!tgt_manual) begin
            req_ready = ($urandom_range(99) < rdy_p);
            rsp_valid = (m_eng == WT) && ($urandom_range(99) < rsp_p);
            rsp_rdata = fix_en ? fix_rdata : $urandom;
            rsp_err   = rsp_valid && ($urandom_range(99) < err_p);
        end
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_cmd(input bit w, input bit r, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        wr_en = w; rd_en = r; addr = a; wdata = d; pstrb = s;
        step();
        wr_en = 0; rd_en = 0;
    endtask

    task automatic wait_rresp(input string tag, input int lim);
        for (int k = 0; k < lim; k++) begin
            step();
            if (rresp === 1'b1) break;
        end
        chk(tag, 64'(rresp), 64'd1);
    endtask

    initial begin
        rst = 1; wr_en = 0; rd_en = 0; addr = 0; wdata = 0; pstrb = 0; fuse = 1;
        perr_clr = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0;
        rdy_p = 0; rsp_p = 0; err_p = 0; tgt_manual = 0; fix_en = 0; fix_rdata = 0;
        repeat (3) step();
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        rst = 0;
        step();

        // 1: posted write, launch latency and clean completion
        drive_cmd(1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("t1_wresp", 64'(wresp), 64'd1);
        chk("t1_slverr", 64'(slverr), 64'd0);
        chk("t1_rv_n0", 64'(req_valid), 64'd0);
        step();
        chk("t1_rv_n1", 64'(req_valid), 64'd0);
        step();
        chk("t1_rv_n2", 64'(req_valid), 64'd1);
        chk("t1_req_write", 64'(req_write), 64'd1);
        chk("t1_req_addr", 64'(req_addr), 64'h10);
        rdy_p = 100; rsp_p = 100;
        repeat (6) step();
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_perr", 64'(perr), 64'd0);

        // 2: stalled target fills the queue, read rejected, later read returns data
        rdy_p = 0; rsp_p = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1, 0, 32'(i * 4), $urandom, 4'hF);
            step();
        end
        chk("t2_full", 64'(full), 64'd1);
        drive_cmd(0, 1, 32'h100, 0, 0);
        chk("t2_rej_rresp", 64'(rresp), 64'd1);
        chk("t2_rej_slverr", 64'(slverr), 64'd1);
        chk("t2_rej_inv", 64'(inv_addr), 64'd0);
        rdy_p = 100; rsp_p = 100; fix_en = 1; fix_rdata = 32'h87654321;
        repeat (20) step();
        drive_cmd(0, 1, 32'h20, 0, 0);
        wait_rresp("t2_rd_seen", 40);
        chk("t2_rdata", 64'(rdata), 64'h87654321);
        chk("t2_rd_slverr", 64'(slverr), 64'd0);
        fix_en = 0;

        // 3: out-of-window read
        drive_cmd(0, 1, 32'h2000, 0, 0);
        chk("t3_rresp", 64'(rresp), 64'd1);
        chk("t3_slverr", 64'(slverr), 64'd1);
        chk("t3_inv", 64'(inv_addr), 64'd1);
        repeat (4) begin step(); chk("t3_no_req", 64'(req_valid), 64'd0); end

        // 4: fuse blown
        fuse = 0;
        drive_cmd(1, 0, 32'h20, 32'h1, 4'h1);
        chk("t4_wresp", 64'(wresp), 64'd1);
        chk("t4_slverr", 64'(slverr), 64'd1);
        chk("t4_inv", 64'(inv_addr), 64'd0);
        fuse = 1;
        step(); step();
        chk("t4_empty", 64'(empty), 64'd1);

        // 5: read timeout, then posted write error and clear
        rsp_p = 0;
        drive_cmd(0, 1, 32'h4, 0, 0);
        wait_rresp("t5_tmo_seen", 300);
        chk("t5_slverr", 64'(slverr), 64'd1);
        chk("t5_rdata", 64'(rdata), 64'd0);
        rsp_p = 100; err_p = 100;
        drive_cmd(1, 0, 32'h8, 32'h5, 4'h3);
        for (int k = 0; k < 20 && perr !== 1'b1; k++) step();
        chk("t5_perr", 64'(perr), 64'd1);
        err_p = 0;
        perr_clr = 1; step(); perr_clr = 0;
        chk("t5_perr_clr", 64'(perr), 64'd0);

        // 6: reset while a request is in flight, late response ignored
        rsp_p = 0;
        drive_cmd(1, 0, 32'h0, 32'hA, 4'hF);
        drive_cmd(1, 0, 32'h4, 32'hB, 4'hF);
        drive_cmd(1, 0, 32'h8, 32'hC, 4'hF);
        repeat (5) step();
        rst = 1; step(); rst = 0;
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_req_valid", 64'(req_valid), 64'd0);
        tgt_manual = 1; rsp_valid = 1; rsp_rdata = 32'h1234; step();
        rsp_valid = 0; step();
        chk("t6_no_rresp", 64'(rresp), 64'd0);
        chk("t6_no_wresp", 64'(wresp), 64'd0);
        tgt_manual = 0;

        // random traffic
        rdy_p = 60; rsp_p = 30; err_p = 15;
        for (int n = 0; n < 1500; n++) begin
            int t = $urandom_range(99);
            int s = $urandom_range(99);
            wr_en = 0; rd_en = 0;
            if (t < 30) begin
                if (s < 45)      wr_en = 1;
                else if (s < 90) rd_en = 1;
                else begin wr_en = 1; rd_en = 1; end
                s = $urandom_range(99);
                if (s < 80)      addr = 32'($urandom_range(1023) * 4);
                else if (s < 90) addr = 32'($urandom_range(1023) * 4 + $urandom_range(1, 3));
                else             addr = 32'h1000 + 32'($urandom_range(255) * 4);
                wdata = $urandom;
                pstrb = 4'($urandom);
            end
            fuse     = ($urandom_range(99) < 95);
            perr_clr = ($urandom_range(99) < 5);
            step();
        end
        wr_en = 0; rd_en = 0; fuse = 1; perr_clr = 0;
        rdy_p = 100; rsp_p = 100; err_p = 0;
        repeat (40) step();
        chk("drain_empty", 64'(empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
